// File: rtl/result_accum_pack_if.sv
// result_accum_pack_if
// Bundles the psum handshake from the PE array, the per-layer controls
// (layer_start, bias, flush) and the write port into the result memory.
// slave is the view of result_accum_pack; master is the view of whoever drives it.
interface result_accum_pack_if #(
    parameter int CNT_W = 16
);
    logic             layer_start;
    logic             psum_valid;
    logic [31:0]      psum_data;
    logic             psum_ready;
    logic [31:0]      bias;
    logic             flush;
    logic             write_result_signal;
    logic [31:0]      write_result_data;
    logic [CNT_W-1:0] result_count;

    modport master (
        output layer_start, psum_valid, psum_data, bias, flush,
        input  psum_ready, write_result_signal, write_result_data, result_count
    );

    modport slave (
        input  layer_start, psum_valid, psum_data, bias, flush,
        output psum_ready, write_result_signal, write_result_data, result_count
    );
endinterface

// File: rtl/result_accum_pack.sv
// result_accum_pack
// Accumulates ACC_CNT signed partial sums per output pixel (seeded with a
// per-pixel bias), rescales by an arithmetic right shift, saturates to 16 bits
// and packs two pixels per 32-bit word for the result memory.
// Build option: define RESULT_RELU_EN to clamp pixels to [0, 32767] (ReLU);
// otherwise pixels saturate to the signed range [-32768, 32767].
module result_accum_pack #(
    parameter int ACC_CNT = 3,
    parameter int SHIFT   = 8,
    parameter int CNT_W   = 16
) (
    input logic                clk,
    input logic                rst,
    result_accum_pack_if.slave bus
);
    localparam int               IDX_W    = (ACC_CNT > 1) ? $clog2(ACC_CNT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ACC_CNT - 1);

    typedef enum logic [1:0] {
        ACCUM,
        POST,
        WRITE
    } state_t;

    state_t             state;
    logic signed [39:0] acc;
    logic [IDX_W-1:0]   psum_idx;
    logic               half_sel;
    logic [15:0]        low_hold;
    logic               write_result_signal;
    logic [31:0]        write_result_data;
    logic [CNT_W-1:0]   result_count;

    logic               flush_take;
    logic               psum_ready;
    logic               xfer;
    logic signed [39:0] psum_ext;
    logic signed [39:0] bias_ext;
    logic signed [39:0] acc_sum;
    logic signed [39:0] shifted;
    logic [15:0]        sat_val;

    // A flush only makes sense between pixels with a lone low half waiting;
    // it steals the cycle, so no psum is taken alongside it.
    assign flush_take = (state == ACCUM) && bus.flush && !bus.layer_start &&
                        (psum_idx == '0) && half_sel;
    assign psum_ready = (state == ACCUM) && !bus.layer_start && !flush_take;
    assign xfer       = bus.psum_valid && psum_ready;

    assign psum_ext = {{8{bus.psum_data[31]}}, bus.psum_data};
    assign bias_ext = {{8{bus.bias[31]}}, bus.bias};
    assign acc_sum  = ((psum_idx == '0) ? bias_ext : acc) + psum_ext;
    assign shifted  = acc >>> SHIFT;

    assign bus.psum_ready          = psum_ready;
    assign bus.write_result_signal = write_result_signal;
    assign bus.write_result_data   = write_result_data;
    assign bus.result_count        = result_count;

    // Rescaled accumulator clipped to a 16-bit pixel (ReLU or signed saturation).
    always_comb begin
        sat_val = shifted[15:0];
`ifdef RESULT_RELU_EN
        if (shifted < 40'sd0) begin
            sat_val = 16'h0000;
        end else if (shifted > 40'sd32767) begin
            sat_val = 16'h7FFF;
        end
`else
        if (shifted > 40'sd32767) begin
            sat_val = 16'h7FFF;
        end else if (shifted < -40'sd32768) begin
            sat_val = 16'h8000;
        end
`endif
    end

    // Pixel FSM: accumulate psums, post-process one cycle, emit a packed word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= ACCUM;
            acc                 <= '0;
            psum_idx            <= '0;
            half_sel            <= 1'b0;
            low_hold            <= '0;
            write_result_signal <= 1'b0;
            write_result_data   <= '0;
            result_count        <= '0;
        end else if (bus.layer_start) begin
            state               <= ACCUM;
            acc                 <= '0;
            psum_idx            <= '0;
            half_sel            <= 1'b0;
            low_hold            <= '0;
            write_result_signal <= 1'b0;
            write_result_data   <= '0;
            result_count        <= '0;
        end else begin
            write_result_signal <= 1'b0;
            write_result_data   <= '0;
            case (state)
                ACCUM: begin
                    if (flush_take) begin
                        write_result_signal <= 1'b1;
                        write_result_data   <= {16'h0000, low_hold};
                        result_count        <= result_count + 1'b1;
                        half_sel            <= 1'b0;
                        state               <= WRITE;
                    end else if (xfer) begin
                        acc <= acc_sum;
                        if (psum_idx == LAST_IDX) begin
                            psum_idx <= '0;
                            state    <= POST;
                        end else begin
                            psum_idx <= psum_idx + 1'b1;
                        end
                    end
                end
                POST: begin
                    if (!half_sel) begin
                        low_hold <= sat_val;
                        half_sel <= 1'b1;
                        state    <= ACCUM;
                    end else begin
                        write_result_signal <= 1'b1;
                        write_result_data   <= {sat_val, low_hold};
                        result_count        <= result_count + 1'b1;
                        half_sel            <= 1'b0;
                        state               <= WRITE;
                    end
                end
                WRITE: begin
                    state <= ACCUM;
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_result_accum_pack.sv
// tb_result_accum_pack
// Drives pixels (directed cases, then random ones) into result_accum_pack and
// compares every written word and the word counter against a reference model
// that computes pixels with plain integer arithmetic. Honours RESULT_RELU_EN.
module tb_result_accum_pack;
    localparam int ACC_CNT = 3;
    localparam int SHIFT   = 8;
    localparam int CNT_W   = 16;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    logic [31:0]      exp_word[$];
    logic [CNT_W-1:0] exp_cnt[$];
    int               rd_idx = 0;

    logic             m_half;
    logic [15:0]      m_low;
    logic [CNT_W-1:0] m_count;

    result_accum_pack_if #(.CNT_W(CNT_W)) bus ();

    result_accum_pack #(
        .ACC_CNT (ACC_CNT),
        .SHIFT   (SHIFT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [15:0] refPixel(input int b, input int p0, input int p1, input int p2);
        longint sum;
        longint v;
        sum = longint'(b) + longint'(p0) + longint'(p1) + longint'(p2);
        v   = sum >>> SHIFT;
`ifdef RESULT_RELU_EN
        if (v < 0) v = 0;
        if (v > 32767) v = 32767;
`else
        if (v < -32768) v = -32768;
        if (v > 32767) v = 32767;
`endif
        return v[15:0];
    endfunction

    task automatic modelPixel(input logic [15:0] v);
        if (!m_half) begin
            m_low  = v;
            m_half = 1'b1;
        end else begin
            m_count++;
            exp_word.push_back({v, m_low});
            exp_cnt.push_back(m_count);
            m_half = 1'b0;
        end
    endtask

    task automatic sendPsum(input int d);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!bus.psum_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("psum_ready_wait", bus.psum_ready, 1);
        bus.psum_valid = 1'b1;
        bus.psum_data  = d;
        @(posedge clk);
        #1;
        bus.psum_valid = 1'b0;
        bus.psum_data  = $urandom;
    endtask

    task automatic applyStimulus(input int b, input int p0, input int p1, input int p2, input int gap);
        int ps[3];
        ps = '{p0, p1, p2};
        bus.bias = b;
        for (int i = 0; i < ACC_CNT; i++) begin
            sendPsum(ps[i]);
            if (i == 0) bus.bias = $urandom;
            repeat (gap) @(negedge clk);
        end
        modelPixel(refPixel(b, p0, p1, p2));
    endtask

    task automatic doFlush();
        int waited;
        waited = 0;
        @(negedge clk);
        while (!bus.psum_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        bus.flush = 1'b1;
        #1;
        checkOutput("flush_ready", bus.psum_ready, !m_half);
        if (m_half) begin
            m_count++;
            exp_word.push_back({16'h0000, m_low});
            exp_cnt.push_back(m_count);
            m_half = 1'b0;
        end
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
    endtask

    task automatic doLayerStart(input logic with_valid);
        @(negedge clk);
        bus.layer_start = 1'b1;
        bus.psum_valid  = with_valid;
        bus.psum_data   = $urandom;
        #1;
        checkOutput("ls_ready", bus.psum_ready, 0);
        @(posedge clk);
        #1;
        bus.layer_start = 1'b0;
        bus.psum_valid  = 1'b0;
        m_half  = 1'b0;
        m_count = '0;
        checkOutput("ls_count", bus.result_count, 0);
        checkOutput("ls_strobe", bus.write_result_signal, 0);
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        @(negedge clk);
        while ((rd_idx != exp_word.size() || !bus.psum_ready) && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("drain", rd_idx == exp_word.size(), 1);
    endtask

    // Scoreboard: every strobe must match the next expected word and count;
    // between strobes the data bus must read zero.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.write_result_signal) begin
                checkOutput("strobe_ready_low", bus.psum_ready, 0);
                checkOutput("strobe_expected", rd_idx < exp_word.size(), 1);
                if (rd_idx < exp_word.size()) begin
                    checkOutput("word", bus.write_result_data, exp_word[rd_idx]);
                    checkOutput("count", bus.result_count, exp_cnt[rd_idx]);
                    rd_idx++;
                end
            end else begin
                checkOutput("idle_data", bus.write_result_data, 0);
            end
        end
    end

    // Last-resort guard; every wait in the stimulus is already bounded.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        int b, p0, p1, p2;
        rst             = 1'b1;
        bus.layer_start = 1'b0;
        bus.psum_valid  = 1'b0;
        bus.psum_data   = '0;
        bus.bias        = '0;
        bus.flush       = 1'b0;
        m_half          = 1'b0;
        m_low           = '0;
        m_count         = '0;

        repeat (2) @(negedge clk);
        checkOutput("rst_strobe", bus.write_result_signal, 0);
        checkOutput("rst_data", bus.write_result_data, 0);
        checkOutput("rst_count", bus.result_count, 0);
        checkOutput("rst_ready", bus.psum_ready, 1);
        rst = 1'b0;

        $display("[TB] basic pair and latency");
        applyStimulus(256, 512, 768, 1024, 0);
        applyStimulus(0, -1000, 0, 0, 0);
        @(negedge clk);
        checkOutput("latency_post", bus.write_result_signal, 0);
        @(negedge clk);
        checkOutput("latency_write", bus.write_result_signal, 1);
        drain();
        checkOutput("pair_count", bus.result_count, m_count);

        $display("[TB] saturation");
        applyStimulus(0, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 0);
        applyStimulus(0, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 0);
        drain();

        $display("[TB] negative pixel");
        applyStimulus(-2560, 0, 0, 0, 0);
        applyStimulus(2560, 0, 0, 0, 0);
        drain();

        $display("[TB] flush");
        applyStimulus(1280, 0, 0, 0, 0);
        doFlush();
        doFlush();
        drain();

        $display("[TB] stalled psums");
        applyStimulus(256, 512, 768, 1024, 1);
        applyStimulus(-5000, 100, -200, 300, 2);
        drain();

        $display("[TB] layer_start mid-pixel");
        sendPsum(4000);
        sendPsum(5000);
        doLayerStart(1'b1);
        applyStimulus(768, 256, 0, 0, 0);
        applyStimulus(0, 0, 0, 2816, 0);
        drain();

        $display("[TB] reset during a strobe");
        applyStimulus(256, 0, 0, 0, 0);
        applyStimulus(512, 0, 0, 0, 0);
        waited = 0;
        @(negedge clk);
        while (!bus.write_result_signal && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("rst_strobe_seen", bus.write_result_signal, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_strobe", bus.write_result_signal, 0);
        checkOutput("async_rst_data", bus.write_result_data, 0);
        checkOutput("async_rst_count", bus.result_count, 0);
        m_half  = 1'b0;
        m_count = '0;
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] reset mid-pixel");
        sendPsum(1000);
        sendPsum(2000);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midpix_rst_count", bus.result_count, 0);
        checkOutput("midpix_rst_ready", bus.psum_ready, 1);
        m_half  = 1'b0;
        m_count = '0;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 2560, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        drain();
        checkOutput("midpix_recover_count", bus.result_count, 1);

        $display("[TB] random pixels");
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                b  = $urandom;
                p0 = $urandom;
                p1 = $urandom;
                p2 = $urandom;
            end else begin
                b  = int'($urandom_range(0, 400000)) - 200000;
                p0 = int'($urandom_range(0, 400000)) - 200000;
                p1 = int'($urandom_range(0, 400000)) - 200000;
                p2 = int'($urandom_range(0, 400000)) - 200000;
            end
            applyStimulus(b, p0, p1, p2, int'($urandom_range(0, 2)));
            if ($urandom_range(0, 7) == 0) doFlush();
            if ($urandom_range(0, 19) == 0) begin
                drain();
                doLayerStart(1'($urandom_range(0, 1)));
            end
        end
        drain();
        checkOutput("final_count", bus.result_count, m_count);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
